// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared ALU operation codes and load/store opcodes for the
//               MIPS EX/MEM datapath slice.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

   // ALU operation codes (alu_op)
   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_XOR   = 4'd4;
   localparam logic [3:0] ALU_NOR   = 4'd5;
   localparam logic [3:0] ALU_SLT   = 4'd6;
   localparam logic [3:0] ALU_SLTU  = 4'd7;
   localparam logic [3:0] ALU_SLL   = 4'd8;
   localparam logic [3:0] ALU_SRL   = 4'd9;
   localparam logic [3:0] ALU_SRA   = 4'd10;
   localparam logic [3:0] ALU_LUI   = 4'd11;
   localparam logic [3:0] ALU_PASSB = 4'd12;

   // Primary opcodes (instr[31:26]) of the memory instructions
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Combinational 32-bit MIPS ALU with zero flag. All arithmetic
//               wraps mod 2^32; shifts use only the low five bits of A.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
   import mips_pkg::*;
(
   input  logic [3:0]  alu_op,
   input  logic [31:0] alu_a,
   input  logic [31:0] alu_b,
   output logic [31:0] alu_c,
   output logic        alu_zero
);

   logic [4:0] shamt;

   assign shamt = alu_a[4:0];

   // Operation select; unassigned codes (13-15) yield zero
   always_comb begin
      alu_c = 32'd0;
      case (alu_op)
         ALU_ADD:   alu_c = alu_a + alu_b;
         ALU_SUB:   alu_c = alu_a - alu_b;
         ALU_AND:   alu_c = alu_a & alu_b;
         ALU_OR:    alu_c = alu_a | alu_b;
         ALU_XOR:   alu_c = alu_a ^ alu_b;
         ALU_NOR:   alu_c = ~(alu_a | alu_b);
         ALU_SLT:   alu_c = {31'd0, ($signed(alu_a) < $signed(alu_b))};
         ALU_SLTU:  alu_c = {31'd0, (alu_a < alu_b)};
         ALU_SLL:   alu_c = alu_b << shamt;
         ALU_SRL:   alu_c = alu_b >> shamt;
         ALU_SRA:   alu_c = $unsigned($signed(alu_b) >>> shamt);
         ALU_LUI:   alu_c = {alu_b[15:0], 16'h0000};
         ALU_PASSB: alu_c = alu_b;
         default:   alu_c = 32'd0;
      endcase
   end

   assign alu_zero = (alu_c == 32'd0);

endmodule : alu_core
`default_nettype wire

// File: rtl/exmem_alu_lsu.sv
`default_nettype none
// ============================================================================
// Module      : exmem_alu_lsu
// Description : EX/MEM slice of the 5-stage MIPS pipeline. Combinational ALU,
//               EX->MEM pipeline register, store byte-enable/lane generation
//               and load extraction with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module exmem_alu_lsu
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  alu_op,
   input  logic [31:0] alu_a,
   input  logic [31:0] alu_b,
   input  logic [31:0] st_data,
   input  logic [5:0]  ex_opcode,
   output logic [31:0] alu_c,
   output logic        alu_zero,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [31:0] load_data
);

   logic [31:0] res_d, res_q;
   logic [31:0] st_d,  st_q;
   logic [5:0]  op_d,  op_q;
   logic [1:0]  a;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   alu_core u_alu (
      .alu_op   (alu_op),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_c    (alu_c),
      .alu_zero (alu_zero)
   );

   // Pipeline register inputs: capture every cycle, no stall
   always_comb begin
      res_d = alu_c;
      st_d  = st_data;
      op_d  = ex_opcode;
   end

   // EX->MEM register; reset clears to opcode 0, which is a non-memory op
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q <= 32'd0;
         st_q  <= 32'd0;
         op_q  <= 6'd0;
      end else begin
         res_q <= res_d;
         st_q  <= st_d;
         op_q  <= op_d;
      end
   end

   assign mem_addr = res_q;
   assign a        = res_q[1:0];

   // Store byte enables and lane-replicated write data (little-endian lanes)
   always_comb begin
      mem_be    = 4'b0000;
      mem_wdata = st_q;
      case (op_q)
         OP_SB: begin
            mem_be    = 4'b0001 << a;
            mem_wdata = {4{st_q[7:0]}};
         end
         OP_SH: begin
            mem_be    = a[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{st_q[15:0]}};
         end
         OP_SW: begin
            mem_be    = 4'b1111;
            mem_wdata = st_q;
         end
         default: ;
      endcase
   end

   // Byte and halfword lane selection from the returned word
   always_comb begin
      byte_sel = mem_rdata[7:0];
      case (a)
         2'd0: byte_sel = mem_rdata[7:0];
         2'd1: byte_sel = mem_rdata[15:8];
         2'd2: byte_sel = mem_rdata[23:16];
         2'd3: byte_sel = mem_rdata[31:24];
         default: byte_sel = mem_rdata[7:0];
      endcase
      half_sel = a[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   end

   // Load extension; non-load opcodes pass the raw word through
   always_comb begin
      load_data = mem_rdata;
      case (op_q)
         OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU: load_data = {24'd0, byte_sel};
         OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
         OP_LHU: load_data = {16'd0, half_sel};
         OP_LW:  load_data = mem_rdata;
         default: load_data = mem_rdata;
      endcase
   end

endmodule : exmem_alu_lsu
`default_nettype wire

// File: tb/tb_exmem_alu_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_exmem_alu_lsu
// Description : Self-checking bench for exmem_alu_lsu: directed cases plus
//               randomized instructions against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exmem_alu_lsu;

   localparam logic [5:0] T_LB  = 6'b100000;
   localparam logic [5:0] T_LH  = 6'b100001;
   localparam logic [5:0] T_LW  = 6'b100011;
   localparam logic [5:0] T_LBU = 6'b100100;
   localparam logic [5:0] T_LHU = 6'b100101;
   localparam logic [5:0] T_SB  = 6'b101000;
   localparam logic [5:0] T_SH  = 6'b101001;
   localparam logic [5:0] T_SW  = 6'b101011;

   logic        clk;
   logic        rst;
   logic [3:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] st_data;
   logic [5:0]  ex_opcode;
   logic [31:0] alu_c;
   logic        alu_zero;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [31:0] load_data;

   int total = 0;
   int bad   = 0;

   // model of what the pipeline register currently holds
   logic [31:0] p_res = 32'd0;
   logic [31:0] p_st  = 32'd0;
   logic [5:0]  p_op  = 6'd0;

   exmem_alu_lsu dut (
      .clk       (clk),
      .rst       (rst),
      .alu_op    (alu_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .st_data   (st_data),
      .ex_opcode (ex_opcode),
      .alu_c     (alu_c),
      .alu_zero  (alu_zero),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .load_data (load_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      longint sa, sb;
      logic [31:0] r;
      sh = int'(a % 32);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         0:  r = 32'(longint'(a) + longint'(b));
         1:  r = 32'(longint'(a) - longint'(b));
         2:  r = a & b;
         3:  r = a | b;
         4:  r = a ^ b;
         5:  r = ~(a | b);
         6:  r = (sa < sb) ? 32'd1 : 32'd0;
         7:  r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
         8:  r = 32'(longint'(b) * (64'd1 << sh));
         9:  r = 32'(longint'(b) / (64'd1 << sh));
         10: begin
            // floor division of a signed value by 2^sh
            sa = sb / (64'sd1 << sh);
            if (sb < 0 && (sb % (64'sd1 << sh)) != 0) sa = sa - 1;
            r = 32'(sa);
         end
         11: r = 32'(longint'(b) * 65536);
         12: r = b;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   function automatic logic [35:0] store_ref(input logic [5:0] opc, input logic [31:0] addr, input logic [31:0] st);
      int off;
      logic [3:0]  be;
      logic [31:0] wd;
      off = int'(addr % 4);
      be  = 4'd0;
      wd  = st;
      if (opc == T_SB) begin
         be = 4'(1 << off);
         wd = (st % 256) * 32'h01010101;
      end else if (opc == T_SH) begin
         be = (off >= 2) ? 4'hC : 4'h3;
         wd = (st % 65536) * 32'h00010001;
      end else if (opc == T_SW) begin
         be = 4'hF;
      end
      return {be, wd};
   endfunction

   function automatic logic [31:0] load_ref(input logic [5:0] opc, input logic [31:0] addr, input logic [31:0] rd);
      int off;
      longint bv, hv;
      off = int'(addr % 4);
      bv  = longint'((rd >> (8 * off)) % 256);
      hv  = longint'((rd >> ((off >= 2) ? 16 : 0)) % 65536);
      case (opc)
         T_LB:  return 32'((bv > 127) ? bv - 256 : bv);
         T_LBU: return 32'(bv);
         T_LH:  return 32'((hv > 32767) ? hv - 65536 : hv);
         T_LHU: return 32'(hv);
         default: return rd;
      endcase
   endfunction

   // Present one instruction, check EX outputs, cross an edge, check MEM outputs
   task automatic do_instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] st, input logic [5:0] opc, input logic [31:0] rd);
      logic [31:0] exp;
      logic [35:0] sv;
      alu_op = op; alu_a = a; alu_b = b; st_data = st; ex_opcode = opc;
      #1;
      exp = alu_ref(int'(op), a, b);
      chk("alu_c", alu_c, exp);
      chk("alu_zero", {31'd0, alu_zero}, {31'd0, (exp == 32'd0)});
      sv = store_ref(p_op, p_res, p_st);
      chk("be_before_edge", {28'd0, mem_be}, {28'd0, sv[35:32]});
      @(posedge clk);
      #1;
      p_res = exp; p_st = st; p_op = opc;
      sv = store_ref(p_op, p_res, p_st);
      chk("mem_addr", mem_addr, p_res);
      chk("mem_be", {28'd0, mem_be}, {28'd0, sv[35:32]});
      chk("mem_wdata", mem_wdata, sv[31:0]);
      mem_rdata = rd;
      #1;
      chk("load_data", load_data, load_ref(p_op, p_res, rd));
   endtask

   initial begin
      logic [5:0] opc_tab [8];
      opc_tab = '{T_LB, T_LH, T_LW, T_LBU, T_LHU, T_SB, T_SH, T_SW};
      rst = 1'b1; alu_op = 4'd0; alu_a = 32'd0; alu_b = 32'd0;
      st_data = 32'd0; ex_opcode = 6'd0; mem_rdata = 32'h12345678;
      @(posedge clk); #1;
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_be", {28'd0, mem_be}, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_load", load_data, 32'h12345678);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // ALU directed
      do_instr(4'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 6'd0, 32'd0);
      chk("add_ovf", mem_addr, 32'h80000000);
      do_instr(4'd1, 32'd5, 32'd5, 32'd0, 6'd0, 32'd0);
      chk("sub_zero", mem_addr, 32'd0);
      do_instr(4'd6, 32'hFFFFFFFF, 32'd1, 32'd0, 6'd0, 32'd0);
      chk("slt", mem_addr, 32'd1);
      do_instr(4'd7, 32'hFFFFFFFF, 32'd1, 32'd0, 6'd0, 32'd0);
      chk("sltu", mem_addr, 32'd0);
      do_instr(4'd10, 32'd4, 32'h80000000, 32'd0, 6'd0, 32'd0);
      chk("sra", mem_addr, 32'hF8000000);
      do_instr(4'd11, 32'd0, 32'h1234, 32'd0, 6'd0, 32'd0);
      chk("lui", mem_addr, 32'h12340000);
      do_instr(4'd14, 32'hDEADBEEF, 32'h1234, 32'd0, 6'd0, 32'd0);
      chk("op14", mem_addr, 32'd0);

      // Stores
      do_instr(4'd0, 32'h13, 32'd0, 32'hAABBCCDD, T_SB, 32'd0);
      chk("sb_be", {28'd0, mem_be}, 32'h8);
      chk("sb_wd", mem_wdata, 32'hDDDDDDDD);
      do_instr(4'd0, 32'h12, 32'd0, 32'hAABBCCDD, T_SH, 32'd0);
      chk("sh_be", {28'd0, mem_be}, 32'hC);
      chk("sh_wd", mem_wdata, 32'hCCDDCCDD);
      do_instr(4'd0, 32'h10, 32'd0, 32'hAABBCCDD, T_SW, 32'd0);
      chk("sw_be", {28'd0, mem_be}, 32'hF);
      chk("sw_wd", mem_wdata, 32'hAABBCCDD);
      // ADD right after SW: be drops to 0000 exactly one edge later
      do_instr(4'd0, 32'h10, 32'd0, 32'hAABBCCDD, 6'd0, 32'd0);
      chk("nop_be", {28'd0, mem_be}, 32'h0);

      // Loads
      do_instr(4'd0, 32'd2, 32'd0, 32'd0, T_LB, 32'h80FF7F01);
      chk("lb2", load_data, 32'hFFFFFFFF);
      do_instr(4'd0, 32'd2, 32'd0, 32'd0, T_LBU, 32'h80FF7F01);
      chk("lbu2", load_data, 32'h000000FF);
      do_instr(4'd0, 32'd1, 32'd0, 32'd0, T_LB, 32'h80FF7F01);
      chk("lb1", load_data, 32'h0000007F);
      do_instr(4'd0, 32'd2, 32'd0, 32'd0, T_LH, 32'h80FF7F01);
      chk("lh2", load_data, 32'hFFFF80FF);
      do_instr(4'd0, 32'd0, 32'd0, 32'd0, T_LHU, 32'h80FF7F01);
      chk("lhu0", load_data, 32'h00007F01);
      do_instr(4'd0, 32'd0, 32'd0, 32'd0, T_LW, 32'h80FF7F01);
      chk("lw", load_data, 32'h80FF7F01);

      // Asynchronous reset between edges with a SW held
      do_instr(4'd0, 32'h20, 32'd0, 32'h11223344, T_SW, 32'h55AA55AA);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_be", {28'd0, mem_be}, 32'h0);
      chk("arst_addr", mem_addr, 32'd0);
      chk("arst_load", load_data, 32'h55AA55AA);
      @(posedge clk); #1;
      chk("arst_hold_be", {28'd0, mem_be}, 32'h0);
      rst = 1'b0;
      #2;
      chk("arst_post_be", {28'd0, mem_be}, 32'h0);
      chk("arst_post_addr", mem_addr, 32'd0);
      p_res = 32'd0; p_st = 32'd0; p_op = 6'd0;
      do_instr(4'd0, 32'h20, 32'd0, 32'h11223344, T_SW, 32'h0);
      chk("post_rst_sw_be", {28'd0, mem_be}, 32'hF);

      // Randomized instructions against the model
      for (int i = 0; i < 300; i++) begin
         logic [5:0] opc;
         if ($urandom_range(0, 3) == 0) opc = 6'($urandom);
         else opc = opc_tab[$urandom_range(0, 7)];
         do_instr(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, opc, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_exmem_alu_lsu
`default_nettype wire

// File: doc/exmem_alu_lsu.md
Name: exmem_alu_lsu

Overview:
- EX/MEM datapath slice of the 5-stage MIPS pipeline.
- EX half: combinational 32-bit ALU.
- EX→MEM register captures the ALU result, store data and opcode.
- MEM half:
  - generates byte enables and lane-aligned write data for the data memory;
  - extracts, aligns and sign- or zero-extends load data returned by the memory.

Parameters:
- none (datapath fixed at 32 bits; 4 KiB data memory addressed externally).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- alu_op  in  4  ALU operation code
- alu_a  in  32  ALU operand A (rs, shamt, or constant)
- alu_b  in  32  ALU operand B (rt, sign/zero-extended immediate)
- st_data  in  32  forwarded rt value for stores
- ex_opcode  in  6  instr[31:26] of the EX-stage instruction
- alu_c  out  32  combinational ALU result
- alu_zero  out  1  alu_c == 0
- mem_addr  out  32  registered ALU result (memory address / ALU result to WB)
- mem_be  out  4  byte enables for the MEM-stage store
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  raw word read from data memory
- load_data  out  32  aligned and extended load result

Behaviour:
- ALU, combinational, all results mod 2^32, no overflow trap:
  - 0 ADD: A+B
  - 1 SUB: A−B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOR: ~(A|B)
  - 6 SLT: signed A<B → 1, else 0
  - 7 SLTU: unsigned A<B → 1, else 0
  - 8 SLL: B << A[4:0]
  - 9 SRL: B >> A[4:0], logical
  - 10 SRA: B >>> A[4:0], arithmetic
  - 11 LUI: B << 16
  - 12 PASSB: B
  - 13–15: 0
  - Shift operations ignore A[31:5].
- alu_zero = (alu_c == 0), combinational.
- EX→MEM register (captured every rising clk, no stall):
  - r_res ← alu_c
  - r_st ← st_data
  - r_op ← ex_opcode
- rst asserted, any time including mid-operation:
  - all three registers clear to 0 immediately;
  - hence mem_addr = 0, mem_be = 0000, mem_wdata = 0;
  - load_data = mem_rdata (opcode 0 is pass-through).
- Latency: alu_c at 0 cycles; mem_* and load_data reflect the instruction presented one clk edge earlier.
- Byte lanes are little-endian: address offset k maps to bits [8k+7:8k] and be[k].
- Let a = r_res[1:0]. Byte enables and write data from r_op:
  - SB 101000: be = 0001 << a; wdata = {4{r_st[7:0]}}.
  - SH 101001: be = a[1] ? 1100 : 0011; wdata = {2{r_st[15:0]}}; a[0] ignored.
  - SW 101011: be = 1111; wdata = r_st; a ignored.
  - Any other opcode: be = 0000; wdata = r_st.
- Load handling from r_op (byte selected = mem_rdata[8a+7:8a]; half selected = a[1] ? [31:16] : [15:0]):
  - LB 100000: sign-extend the selected byte.
  - LBU 100100: zero-extend the selected byte.
  - LH 100001: sign-extend the selected half.
  - LHU 100101: zero-extend the selected half.
  - LW 100011: mem_rdata.
  - Any other opcode: mem_rdata (pass-through).
- No alignment exceptions.
- MEM outputs are combinational from registers and mem_rdata; no glitch requirements.

Decomposition:
- Shared package mips_pkg:
  - ALU op constants ALU_ADD..ALU_PASSB (4-bit);
  - opcode constants OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW (6-bit).
- One sub-module alu_core: the combinational ALU with its zero flag.
- Byte-enable logic, store-lane replication and load extraction stay inline in this block.

Test Plan:
- ALU ops:
  - ADD 0x7FFFFFFF+1 → 0x80000000.
  - SUB 5−5 → 0, alu_zero=1.
  - SLT A=0xFFFFFFFF, B=1 → 1; SLTU with the same operands → 0.
  - SRA B=0x80000000, A=4 → 0xF8000000.
  - LUI B=0x1234 → 0x12340000.
  - Op 14 → 0.
- Stores, st_data=0xAABBCCDD:
  - SB at address 0x13 → be=1000, wdata=0xDDDDDDDD.
  - SH at 0x12 → be=1100, wdata=0xCCDDCCDD.
  - SW at 0x10 → be=1111, wdata=0xAABBCCDD.
  - Opcode 000000 → be=0000.
- Loads, mem_rdata=0x80FF7F01:
  - LB a=2 → 0xFFFFFFFF.
  - LBU a=2 → 0x000000FF.
  - LB a=1 → 0x0000007F.
  - LH a=2 → 0xFFFF80FF.
  - LHU a=0 → 0x00007F01.
  - LW → 0x80FF7F01.
- Pipeline latency: present SW, then ADD on consecutive cycles → mem_be goes 1111 then 0000, exactly one edge after each instruction is presented.
- Reset: assert rst asynchronously between edges while a SW is held in the register → mem_be=0000, mem_addr=0 immediately and held until the first edge after rst deasserts.
